morse_char_decoder: RTL and testbench

MORSE_CHAR_DECODER -- requirements
Module: morse_char_decoder

---
 rtl/morse_char_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_morse_char_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_decoder.sv
// Morse character decoder: turns a five-slot dot/dash sequence into an ASCII
// character (plus an optional word-gap space) and queues it in a small FIFO.
module morse_char_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [9:0] seq_bits,
    input  logic       spa_end,
    input  logic       sent,
    input  logic       flush,
    input  logic       char_ready,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic       decode_err
);
    localparam int         PW        = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DECODE, PUSH_CHAR, PUSH_SPACE} state_t;

    state_t          state_q, state_d;
    logic            sentPrev_q, sentPrev_d;
    logic            armed_q, armed_d;
    logic [9:0]      seqBits_q, seqBits_d;
    logic            spaEnd_q, spaEnd_d;
    logic [7:0]      code_q, code_d;
    logic            codeValid_q, codeValid_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            decodeErr_q, decodeErr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            sentEvent;
    logic            pushEn;
    logic [7:0]      pushData;
    logic            pop;
    logic            pushOk;
    logic            push;
    logic            memWe;
    logic [7:0]      lookedUp;

    // Valid codes are stored exactly as they arrive on seq_bits, so any
    // malformed sequence (illegal slot, symbol after a gap) simply misses.
    function automatic logic [7:0] lookupChar(input logic [9:0] seq);
        logic [7:0] c;
        c = 8'h00;
        case (seq)
            10'b01_10_00_00_00: c = "A";
            10'b10_01_01_01_00: c = "B";
            10'b10_01_10_01_00: c = "C";
            10'b10_01_01_00_00: c = "D";
            10'b01_00_00_00_00: c = "E";
            10'b01_01_10_01_00: c = "F";
            10'b10_10_01_00_00: c = "G";
            10'b01_01_01_01_00: c = "H";
            10'b01_01_00_00_00: c = "I";
            10'b01_10_10_10_00: c = "J";
            10'b10_01_10_00_00: c = "K";
            10'b01_10_01_01_00: c = "L";
            10'b10_10_00_00_00: c = "M";
            10'b10_01_00_00_00: c = "N";
            10'b10_10_10_00_00: c = "O";
            10'b01_10_10_01_00: c = "P";
            10'b10_10_01_10_00: c = "Q";
            10'b01_10_01_00_00: c = "R";
            10'b01_01_01_00_00: c = "S";
            10'b10_00_00_00_00: c = "T";
            10'b01_01_10_00_00: c = "U";
            10'b01_01_01_10_00: c = "V";
            10'b01_10_10_00_00: c = "W";
            10'b10_01_01_10_00: c = "X";
            10'b10_01_10_10_00: c = "Y";
            10'b10_10_01_01_00: c = "Z";
            10'b10_10_10_10_10: c = "0";
            10'b01_10_10_10_10: c = "1";
            10'b01_01_10_10_10: c = "2";
            10'b01_01_01_10_10: c = "3";
            10'b01_01_01_01_10: c = "4";
            10'b01_01_01_01_01: c = "5";
            10'b10_01_01_01_01: c = "6";
            10'b10_10_01_01_01: c = "7";
            10'b10_10_10_01_01: c = "8";
            10'b10_10_10_10_01: c = "9";
            default:            c = 8'h00;
        endcase
        return c;
    endfunction

    // armed_q keeps a strobe that is already high out of reset from counting
    // as an edge until it has been seen low at least once.
    assign sentEvent  = sent & ~sentPrev_q & armed_q;
    assign lookedUp   = lookupChar(seqBits_q);
    assign char_valid = (count_q != 5'd0);
    assign char_out   = char_valid ? mem_q[rdPtr_q] : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign decode_err = decodeErr_q;

    always_comb begin
        state_d     = state_q;
        sentPrev_d  = sent;
        armed_d     = armed_q | ~sent;
        seqBits_d   = seqBits_q;
        spaEnd_d    = spaEnd_q;
        code_d      = code_q;
        codeValid_d = codeValid_q;
        overflow_d  = overflow_q;
        decodeErr_d = decodeErr_q;
        pushEn      = 1'b0;
        pushData    = 8'h00;

        if (sentEvent && state_q != IDLE) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sentEvent) begin
                    seqBits_d = seq_bits;
                    spaEnd_d  = spa_end;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (seqBits_q == 10'd0) begin
                    codeValid_d = 1'b0;
                end else if (lookedUp == 8'h00) begin
                    code_d      = 8'h3F;
                    codeValid_d = 1'b1;
                    decodeErr_d = 1'b1;
                end else begin
                    code_d      = lookedUp;
                    codeValid_d = 1'b1;
                end
                state_d = PUSH_CHAR;
            end
            PUSH_CHAR: begin
                pushEn   = codeValid_q;
                pushData = code_q;
                state_d  = spaEnd_q ? PUSH_SPACE : IDLE;
            end
            PUSH_SPACE: begin
                pushEn   = 1'b1;
                pushData = 8'h20;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot a full FIFO needs for a push.
        pop     = char_valid & char_ready;
        pushOk  = (count_q < DEPTH_CNT) | pop;
        push    = pushEn & pushOk;
        memWe   = push & ~flush;
        wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
        count_d = count_q + 5'(push) - 5'(pop);
        if (pushEn && !pushOk) begin
            overflow_d = 1'b1;
        end

        if (flush) begin
            state_d     = IDLE;
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = 5'd0;
            overflow_d  = 1'b0;
            decodeErr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            sentPrev_q  <= 1'b0;
            armed_q     <= 1'b0;
            seqBits_q   <= 10'd0;
            spaEnd_q    <= 1'b0;
            code_q      <= 8'h00;
            codeValid_q <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= 5'd0;
            overflow_q  <= 1'b0;
            decodeErr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sentPrev_q  <= sentPrev_d;
            armed_q     <= armed_d;
            seqBits_q   <= seqBits_d;
            spaEnd_q    <= spaEnd_d;
            code_q      <= code_d;
            codeValid_q <= codeValid_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            decodeErr_q <= decodeErr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[wrPtr_q] <= pushData;
        end
    end
endmodule

// File: tb/tb_morse_char_decoder.sv
// Self-checking bench for morse_char_decoder: directed corner cases plus random
// sequences compared against a string-based Morse reference model.
module tb_morse_char_decoder;
    localparam int DEPTH = 8;

    logic       clk;
    logic       Reset;
    logic [9:0] seq_bits;
    logic       spa_end;
    logic       sent;
    logic       flush;
    logic       char_ready;
    logic [7:0] char_out;
    logic       char_valid;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       decode_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mQ[$];
    logic       mOvf;
    logic       mErr;

    string morseTab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };

    morse_char_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .seq_bits   (seq_bits),
        .spa_end    (spa_end),
        .sent       (sent),
        .flush      (flush),
        .char_ready (char_ready),
        .char_out   (char_out),
        .char_valid (char_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .decode_err (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] charOf(input int idx);
        return (idx < 26) ? 8'(65 + idx) : 8'(48 + idx - 26);
    endfunction

    function automatic logic [9:0] encodeChar(input int idx);
        string      p;
        logic [9:0] v;
        p = morseTab[idx];
        v = 10'd0;
        for (int k = 0; k < p.len(); k++) begin
            v[9-2*k -: 2] = (p[k] == 8'h2E) ? 2'b01 : 2'b10;
        end
        return v;
    endfunction

    task automatic modelPush(input logic [7:0] c);
        if (mQ.size() < DEPTH) mQ.push_back(c);
        else mOvf = 1'b1;
    endtask

    // Reference: spell the sequence as a dot/dash string, then look it up.
    task automatic modelEvent(input logic [9:0] seq, input logic spa);
        string      pat;
        logic       bad;
        logic       gap;
        logic [1:0] sym;
        logic [7:0] c;
        pat = "";
        bad = 1'b0;
        gap = 1'b0;
        for (int s = 0; s < 5; s++) begin
            sym = seq[9-2*s -: 2];
            case (sym)
                2'b00: gap = 1'b1;
                2'b01: begin if (gap) bad = 1'b1; pat = {pat, "."}; end
                2'b10: begin if (gap) bad = 1'b1; pat = {pat, "-"}; end
                default: bad = 1'b1;
            endcase
        end
        if (!bad && pat.len() == 0) begin
            if (spa) modelPush(8'h20);
        end else begin
            c = 8'h3F;
            if (!bad) begin
                for (int i = 0; i < 36; i++) begin
                    if (morseTab[i] == pat) c = charOf(i);
                end
            end
            if (c == 8'h3F) mErr = 1'b1;
            modelPush(c);
            if (spa) modelPush(8'h20);
        end
    endtask

    task automatic modelClear;
        mQ.delete();
        mOvf = 1'b0;
        mErr = 1'b0;
    endtask

    // One producer transaction: raise sent for 'hold' cycles, scramble the
    // inputs after capture, and wait long enough for char and space writes.
    task automatic applyStimulus(input logic [9:0] seq, input logic spa,
                                 input int hold);
        seq_bits = seq;
        spa_end  = spa;
        sent     = 1'b1;
        for (int h = 0; h < hold; h++) tick();
        sent     = 1'b0;
        seq_bits = 10'($urandom);
        spa_end  = 1'($urandom);
        for (int h = 0; h < 4; h++) tick();
        modelEvent(seq, spa);
    endtask

    task automatic drainAndCheck;
        int n;
        checkOutput("count", 32'(fifo_count), 32'(mQ.size()));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        checkOutput("decode_err", 32'(decode_err), 32'(mErr));
        n = mQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("valid", 32'(char_valid), 32'd1);
            checkOutput("char", 32'(char_out), 32'(mQ[0]));
            char_ready = 1'b1;
            tick();
            void'(mQ.pop_front());
        end
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
        checkOutput("emptyCount", 32'(fifo_count), 32'd0);
        checkOutput("emptyValid", 32'(char_valid), 32'd0);
        checkOutput("emptyOut", 32'(char_out), 32'h00);
    endtask

    task automatic doFlush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        modelClear();
    endtask

    initial begin
        logic [9:0] seq;
        int         r;
        Reset      = 1'b0;
        seq_bits   = 10'd0;
        spa_end    = 1'b0;
        sent       = 1'b0;
        flush      = 1'b0;
        char_ready = 1'b0;
        modelClear();

        #2;
        checkOutput("rstValid", 32'(char_valid), 32'd0);
        checkOutput("rstCount", 32'(fifo_count), 32'd0);
        checkOutput("rstOut", 32'(char_out), 32'h00);
        checkOutput("rstOvf", 32'(overflow), 32'd0);
        checkOutput("rstErr", 32'(decode_err), 32'd0);
        tick();
        Reset = 1'b1;
        tick();
        tick();

        $display("[TB] single character with consumer ready");
        char_ready = 1'b1;
        seq_bits   = 10'h180;
        spa_end    = 1'b0;
        sent       = 1'b1;
        tick();
        sent     = 1'b0;
        seq_bits = 10'h3FF;
        tick();
        checkOutput("latCount1", 32'(fifo_count), 32'd0);
        tick();
        checkOutput("latValid2", 32'(char_valid), 32'd1);
        checkOutput("latChar2", 32'(char_out), 32'h41);
        checkOutput("latCount2", 32'(fifo_count), 32'd1);
        tick();
        checkOutput("latValid3", 32'(char_valid), 32'd0);
        checkOutput("latCount3", 32'(fifo_count), 32'd0);
        char_ready = 1'b0;
        tick();

        $display("[TB] character followed by word space");
        applyStimulus(10'h2A0, 1'b1, 1);
        checkOutput("oSpaceCount", 32'(fifo_count), 32'd2);
        drainAndCheck();

        $display("[TB] digits and malformed sequences");
        applyStimulus(10'h155, 1'b0, 1);
        applyStimulus(10'h2AA, 1'b0, 2);
        applyStimulus(10'h3C0, 1'b0, 1);
        applyStimulus(10'h104, 1'b0, 3);
        applyStimulus(10'h140, 1'b0, 1);
        applyStimulus(10'h000, 1'b0, 1);
        applyStimulus(10'h000, 1'b1, 1);
        drainAndCheck();

        $display("[TB] flush with pending data and flags");
        applyStimulus(10'h3FF, 1'b0, 1);
        applyStimulus(encodeChar(5), 1'b1, 1);
        doFlush();
        drainAndCheck();

        $display("[TB] event while busy is dropped");
        seq_bits = encodeChar(4);
        spa_end  = 1'b0;
        sent     = 1'b1;
        tick();
        sent     = 1'b0;
        seq_bits = encodeChar(19);
        tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        for (int h = 0; h < 4; h++) tick();
        modelEvent(encodeChar(4), 1'b0);
        mOvf = 1'b1;
        drainAndCheck();
        doFlush();

        $display("[TB] event coincident with flush");
        flush    = 1'b1;
        seq_bits = encodeChar(0);
        sent     = 1'b1;
        tick();
        flush = 1'b0;
        modelClear();
        tick();
        sent = 1'b0;
        for (int h = 0; h < 4; h++) tick();
        drainAndCheck();

        $display("[TB] push into full FIFO with simultaneous pop");
        for (int i = 0; i < DEPTH; i++) applyStimulus(encodeChar(i), 1'b0, 1);
        checkOutput("fullCount", 32'(fifo_count), 32'd8);
        seq_bits = encodeChar(25);
        spa_end  = 1'b0;
        sent     = 1'b1;
        tick();
        sent = 1'b0;
        tick();
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
        void'(mQ.pop_front());
        mQ.push_back(8'h5A);
        checkOutput("pushPopCount", 32'(fifo_count), 32'd8);
        checkOutput("pushPopOvf", 32'(overflow), 32'd0);
        tick();
        tick();
        drainAndCheck();

        $display("[TB] ten characters into an eight-entry FIFO");
        for (int i = 0; i < 10; i++) applyStimulus(encodeChar(i), 1'b0, 1);
        checkOutput("ovfCount", 32'(fifo_count), 32'd8);
        drainAndCheck();
        applyStimulus(encodeChar(10), 1'b0, 1);
        applyStimulus(encodeChar(11), 1'b1, 1);

        $display("[TB] reset between capture and write");
        seq_bits = encodeChar(0);
        spa_end  = 1'b1;
        sent     = 1'b1;
        tick();
        #2 Reset = 1'b0;
        #1;
        checkOutput("midRstCount", 32'(fifo_count), 32'd0);
        checkOutput("midRstValid", 32'(char_valid), 32'd0);
        checkOutput("midRstOut", 32'(char_out), 32'h00);
        checkOutput("midRstOvf", 32'(overflow), 32'd0);
        checkOutput("midRstErr", 32'(decode_err), 32'd0);
        tick();
        Reset = 1'b1;
        modelClear();
        for (int h = 0; h < 5; h++) tick();
        checkOutput("postRstCount", 32'(fifo_count), 32'd0);
        checkOutput("postRstValid", 32'(char_valid), 32'd0);
        checkOutput("postRstOvf", 32'(overflow), 32'd0);
        sent = 1'b0;
        tick();
        applyStimulus(encodeChar(1), 1'b0, 1);
        drainAndCheck();

        $display("[TB] randomized sequences");
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      seq = encodeChar($urandom_range(0, 35));
            else if (r < 9) seq = 10'($urandom);
            else            seq = 10'd0;
            applyStimulus(seq, 1'($urandom_range(0, 3) == 0), $urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) drainAndCheck();
        end
        drainAndCheck();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
